// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide: shift-add multiply or restoring divide, one bit per cycle.
// Normal latency XLEN+2 cycles from start to done; divide-by-zero/overflow finish in 1 cycle.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            done,
  output logic            busy,
  output logic            stall
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;
  localparam int CW = $clog2(XLEN);

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_op;
  logic              r_neg_q, r_neg_r;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opb;
  logic [XLEN-1:0]   r_result;
  logic              r_done;

  logic              w_accept, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic [XLEN-1:0]   w_a_mag, w_b_mag, w_special_res;
  logic              w_div0, w_ovf, w_special, w_last, w_ge;
  logic [XLEN-1:0]   w_hi, w_lo, w_rdiff, w_quo, w_rem, w_fix_res;
  logic [XLEN:0]     w_sum, w_rsh;
  logic [2*XLEN-1:0] w_acc_step, w_prod;

  assign w_a_sgn = (op == 3'b001) | (op == 3'b010) | (op == 3'b100) | (op == 3'b110);
  assign w_b_sgn = (op == 3'b001) | (op == 3'b100) | (op == 3'b110);
  assign w_a_neg = w_a_sgn & a[XLEN-1];
  assign w_b_neg = w_b_sgn & b[XLEN-1];
  assign w_a_mag = w_a_neg ? -a : a;
  assign w_b_mag = w_b_neg ? -b : b;

  assign w_div0        = op[2] & (b == '0);
  assign w_ovf         = op[2] & ~op[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
  assign w_special     = w_div0 | w_ovf;
  assign w_special_res = w_div0 ? (op[1] ? a : '1) : (op[1] ? '0 : a);

  // Accumulator: hi half is partial product / remainder, lo half is multiplier / dividend->quotient.
  assign w_hi   = r_acc[2*XLEN-1:XLEN];
  assign w_lo   = r_acc[XLEN-1:0];
  assign w_sum  = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_opb} : '0);
  assign w_rsh  = {w_hi, w_lo[XLEN-1]};
  assign w_ge   = (w_rsh >= {1'b0, r_opb});
  assign w_rdiff = w_rsh[XLEN-1:0] - r_opb;
  assign w_acc_step = r_op[2] ? {(w_ge ? w_rdiff : w_rsh[XLEN-1:0]), w_lo[XLEN-2:0], w_ge}
                              : {w_sum, w_lo[XLEN-1:1]};
  assign w_last = (r_cnt == CW'(XLEN-1));

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -w_lo : w_lo;
  assign w_rem  = r_neg_r ? -w_hi : w_hi;

  always_comb begin
    w_fix_res = w_rem;
    case (r_op)
      3'b000:                 w_fix_res = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix_res = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix_res = w_quo;
      default:                w_fix_res = w_rem;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_state_nxt = S_IDLE;
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = w_special ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = S_FIXUP;
      end
      S_FIXUP: begin
        busy        = 1'b1;
        w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign stall = busy | (start & (r_state == S_IDLE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_op    <= op;
        r_opb   <= w_b_mag;
        r_acc   <= {{XLEN{1'b0}}, w_a_mag};
        r_cnt   <= '0;
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
        if (w_special) r_result <= w_special_res;
      end else if (r_state == S_CALC) begin
        r_acc <= w_acc_step;
        r_cnt <= r_cnt + 1'b1;
      end else if (r_state == S_FIXUP) begin
        r_result <= w_fix_res;
      end
    end
  end

  assign result = r_result;
  assign done   = r_done;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus pushes expected results, a monitor checks each done pulse.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] result;
  logic        done, busy, stall;

  muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .result(result), .done(done), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          t0_q[$];
  string       nm_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] e, input int lat, input string nm);
    exp_q.push_back(e);
    lat_q.push_back(lat);
    t0_q.push_back(cyc);
    nm_q.push_back(nm);
  endtask

  // Monitor: every done pulse is matched against the oldest outstanding expectation.
  logic [31:0] m_exp;
  int          m_lat, m_t0;
  string       m_nm;
  always @(negedge clk) begin
    if (!reset && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 with result %h, expected no pending op", result);
      end else begin
        m_exp = exp_q.pop_front();
        m_lat = lat_q.pop_front();
        m_t0  = t0_q.pop_front();
        m_nm  = nm_q.pop_front();
        check(m_nm, result, m_exp);
        check({m_nm, "_latency"}, cyc - m_t0, m_lat);
        check({m_nm, "_stall_in_done"}, {31'b0, stall}, 32'd0);
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] e, input int lat, input string nm, input bit do_push,
                       output int s_at);
    @(posedge clk);
    #1;
    op = o; a = x; b = y; start = 1'b1;
    if (do_push) push(e, lat, nm);
    @(negedge clk);
    s_at = stall ? 1 : 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(output int n_stall);
    bit seen;
    seen = 1'b0;
    n_stall = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      else if (stall === 1'b1) n_stall++;
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: got no done within 100 cycles, expected done");
      exp_q.delete(); lat_q.delete(); t0_q.delete(); nm_q.delete();
    end
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] e, input int lat, input string nm);
    int s0, ns;
    issue(o, x, y, e, lat, nm, 1'b1, s0);
    wait_done(ns);
  endtask

  int s0, ns;

  initial begin
    #1 reset = 1'b1;
    #3;
    check("rst_result", result, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    issue(3'b000, 32'd7, 32'd6, 32'd42, 34, "mul_7x6", 1'b1, s0);
    wait_done(ns);
    check("mul_stall_cycles", s0 + ns, 32'd34);

    run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu_ff");
    run(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34, "mulh_m1m1");
    run(3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34, "mulhsu_m1x2");
    run(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh_minmin");
    run(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, "div_m7_2");
    run(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, "rem_m7_2");
    run(3'b101, 32'd100,       32'd7,         32'd14,        34, "divu_100_7");
    run(3'b111, 32'd100,       32'd7,         32'd2,         34, "remu_100_7");
    run(3'b100, 32'h8000_0000, 32'd3,         32'hD555_5556, 34, "div_min_3");
    run(3'b110, 32'h8000_0000, 32'd3,         32'hFFFF_FFFE, 34, "rem_min_3");
    run(3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  "div_by0");
    run(3'b111, 32'd5,         32'd0,         32'd5,         1,  "remu_by0");
    run(3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  "divu_by0");
    run(3'b110, 32'd5,         32'd0,         32'd5,         1,  "rem_by0");
    run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf");
    run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1,  "rem_ovf");

    // A start pulse in the middle of CALC must not disturb the running divide.
    issue(3'b101, 32'd100, 32'd7, 32'd14, 34, "divu_ignore_mid", 1'b1, s0);
    repeat (10) @(posedge clk);
    #1;
    op = 3'b000; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(ns);
    repeat (3) @(posedge clk);

    // Back-to-back: start raised during the DONE cycle.
    issue(3'b000, 32'd7, 32'd6, 32'd42, 34, "b2b_first", 1'b1, s0);
    wait_done(ns);
    op = 3'b101; a = 32'd100; b = 32'd7; start = 1'b1;
    push(32'd14, 34, "b2b_second");
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(ns);

    // Asynchronous reset in the middle of CALC.
    issue(3'b000, 32'd11, 32'd13, 32'd0, 0, "aborted", 1'b0, s0);
    repeat (9) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("abort_result", result, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_stall", {31'b0, stall}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (40) @(posedge clk);

    run(3'b000, 32'd3, 32'd3, 32'd9, 34, "mul_after_reset");
    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
